// File: rtl/uart_rx_if.sv
// Signal bundle between the UART receiver and its environment.
// The slave modport is the receiver; the master modport is the driver and consumer side.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 tick_16x;
  logic                 rx_in;
  logic                 rx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;
  logic                 rts;
  logic                 rx_busy;
  logic [2:0]           state_dbg;

  // Handshake: a word transfers in every clk where rx_valid and rx_ready are both high.
  // rx_data and the error flags stay stable while rx_valid is high and rx_ready is low.
  modport slave (
    input  tick_16x, rx_in, rx_ready,
    output rx_data, rx_valid, parity_err, frame_err, overrun, rts, rx_busy, state_dbg
  );

  modport master (
    output tick_16x, rx_in, rx_ready,
    input  rx_data, rx_valid, parity_err, frame_err, overrun, rts, rx_busy, state_dbg
  );
endinterface

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver with optional parity, 1-2 stop bits,
// a single-entry output register, overrun reporting and break handling.
module uart_rx #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_EN   = 1,
  parameter int PARITY_TYPE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } state_t;

  state_t               r_state;
  logic                 r_sync1;
  logic                 r_sync2;
  logic [3:0]           r_tick;
  logic [3:0]           r_bit_cnt;
  logic                 r_stop_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_bad;
  logic                 r_frm_bad;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_perr;
  logic                 r_ferr;
  logic                 r_overrun;

  logic w_rxs;
  logic w_sample;
  logic w_last_stop;
  logic w_load;

  assign w_rxs       = r_sync2;
  assign w_sample    = bus.tick_16x && (r_tick == 4'd15);
  assign w_last_stop = (r_state == S_STOP) && w_sample &&
                       (int'(r_stop_cnt) == STOP_BITS - 1);
  // A finished frame loads only if the holding register is empty or draining this clk.
  assign w_load      = w_last_stop && (!r_valid || bus.rx_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_tick     <= 4'd0;
      r_bit_cnt  <= 4'd0;
      r_stop_cnt <= 1'b0;
      r_shift    <= '0;
      r_par_bad  <= 1'b0;
      r_frm_bad  <= 1'b0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_sync1   <= bus.rx_in;
      r_sync2   <= r_sync1;
      r_overrun <= 1'b0;

      if (r_valid && bus.rx_ready) r_valid <= 1'b0;

      if (w_last_stop) begin
        if (w_load) begin
          r_data  <= r_shift;
          r_perr  <= r_par_bad;
          r_ferr  <= r_frm_bad | ~w_rxs;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end

      if (bus.tick_16x) begin
        r_tick <= r_tick + 4'd1;
        case (r_state)
          S_IDLE: begin
            if (!w_rxs) begin
              r_state    <= S_START;
              r_tick     <= 4'd0;
              r_bit_cnt  <= 4'd0;
              r_stop_cnt <= 1'b0;
              r_par_bad  <= 1'b0;
              r_frm_bad  <= 1'b0;
            end
          end
          S_START: begin
            // Mid-bit check of the start bit rejects short glitches.
            if (r_tick == 4'd7) begin
              r_tick  <= 4'd0;
              r_state <= w_rxs ? S_IDLE : S_DATA;
            end
          end
          S_DATA: begin
            if (r_tick == 4'd15) begin
              r_tick  <= 4'd0;
              r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
              if (int'(r_bit_cnt) == DATA_BITS - 1)
                r_state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
              else
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
          S_PARITY: begin
            if (r_tick == 4'd15) begin
              r_tick    <= 4'd0;
              r_par_bad <= ((^r_shift) ^ PARITY_TYPE[0]) != w_rxs;
              r_state   <= S_STOP;
            end
          end
          S_STOP: begin
            if (r_tick == 4'd15) begin
              r_tick <= 4'd0;
              if (!w_rxs) r_frm_bad <= 1'b1;
              if (int'(r_stop_cnt) == STOP_BITS - 1)
                r_state <= w_rxs ? S_IDLE : S_WAIT_HIGH;
              else
                r_stop_cnt <= 1'b1;
            end
          end
          S_WAIT_HIGH: begin
            if (w_rxs) begin
              r_tick  <= 4'd0;
              r_state <= S_IDLE;
            end
          end
          default: begin
            r_tick  <= 4'd0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.rx_data    = r_data;
  assign bus.rx_valid   = r_valid;
  assign bus.parity_err = r_perr;
  assign bus.frame_err  = r_ferr;
  assign bus.overrun    = r_overrun;
  assign bus.rts        = ~r_valid;
  assign bus.rx_busy    = (r_state != S_IDLE);
  assign bus.state_dbg  = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table-driven frame vectors, directed corner sequences
// (glitch, overrun, mid-frame reset) and randomized frames against a parity/stop model.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int PT        = 0;
  localparam int NSTOP     = 1;
  localparam int ST_IDLE   = 0;
  localparam int ST_WAITHI = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] tick_div = 2'd0;

  uart_rx_if #(.DATA_BITS(8)) bus ();

  uart_rx #(
    .DATA_BITS(8), .PARITY_EN(1), .PARITY_TYPE(PT), .STOP_BITS(NSTOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // clock / reset / tick generation
  always #5 clk = ~clk;

  always @(posedge clk) begin
    tick_div     <= tick_div + 2'd1;
    bus.tick_16x <= (tick_div == 2'd3);
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // scoreboard state
  logic [9:0] exp_q[$];
  logic [9:0] got_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int ovr_cnt  = 0;
  int busy_ticks = 0;

  always @(negedge clk) begin
    if (!rst && bus.rx_valid && bus.rx_ready)
      got_q.push_back({bus.rx_data, bus.parity_err, bus.frame_err});
    if (!rst && bus.overrun) ovr_cnt++;
    if (!rst && bus.tick_16x && bus.rx_busy) busy_ticks++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // driver tasks
  task automatic wait_ticks(input int n);
    int c;
    c = 0;
    while (c < n) begin
      @(negedge clk);
      if (bus.tick_16x) c++;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pb, input logic sb);
    bus.rx_in = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      bus.rx_in = d[i];
      wait_ticks(16);
    end
    bus.rx_in = pb;
    wait_ticks(16);
    for (int i = 0; i < NSTOP; i++) begin
      bus.rx_in = sb;
      wait_ticks(16);
    end
  endtask

  task automatic check_frame(input string name, input logic [7:0] d, input logic pe, input logic fe);
    logic [9:0] g;
    chk({name, "_count"}, 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) begin
      g = got_q.pop_front();
      chk({name, "_data"}, 32'(g[9:2]), 32'(d));
      chk({name, "_perr"}, 32'(g[1]), 32'(pe));
      chk({name, "_ferr"}, 32'(g[0]), 32'(fe));
    end
    got_q.delete();
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par_bit;
    logic       stop_bit;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [7:0] d;
    logic pb, sb, pe, fe;
    logic [9:0] g, e;

    vecs[0] = '{8'h55, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
    vecs[1] = '{8'h33, 1'b1, 1'b1, 8'h33, 1'b1, 1'b0};
    vecs[2] = '{8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1};
    vecs[3] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[5] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
    vecs[6] = '{8'h07, 1'b1, 1'b0, 8'h07, 1'b0, 1'b1};

    bus.rx_in    = 1'b1;
    bus.rx_ready = 1'b1;
    rst          = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_valid", 32'(bus.rx_valid), 32'd0);
    chk("rst_data",  32'(bus.rx_data), 32'd0);
    chk("rst_rts",   32'(bus.rts), 32'd1);
    chk("rst_busy",  32'(bus.rx_busy), 32'd0);
    chk("rst_ovr",   32'(bus.overrun), 32'd0);
    rst = 1'b0;
    wait_ticks(8);

    // table-driven frames
    for (int v = 0; v < 7; v++) begin
      got_q.delete();
      send_frame(vecs[v].data, vecs[v].par_bit, vecs[v].stop_bit);
      if (!vecs[v].stop_bit) begin
        wait_ticks(24);
        chk($sformatf("vec%0d_wait_high", v), 32'(bus.state_dbg), ST_WAITHI);
        bus.rx_in = 1'b1;
        wait_ticks(4);
        chk($sformatf("vec%0d_idle_after_break", v), 32'(bus.state_dbg), ST_IDLE);
      end
      wait_ticks(8);
      check_frame($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].exp_perr, vecs[v].exp_ferr);
    end

    // short low glitch is rejected as a false start
    got_q.delete();
    busy_ticks = 0;
    bus.rx_in = 1'b0;
    wait_ticks(4);
    bus.rx_in = 1'b1;
    wait_ticks(40);
    chk("glitch_busy_le8", 32'(busy_ticks <= 8), 32'd1);
    chk("glitch_busy_seen", 32'(busy_ticks > 0), 32'd1);
    chk("glitch_no_frame", 32'(got_q.size()), 32'd0);
    chk("glitch_idle", 32'(bus.state_dbg), ST_IDLE);

    // overrun: second frame dropped while the first is held
    got_q.delete();
    ovr_cnt = 0;
    bus.rx_ready = 1'b0;
    send_frame(8'h12, 1'b0, 1'b1);
    send_frame(8'h34, 1'b1, 1'b1);
    wait_ticks(8);
    chk("ovr_valid", 32'(bus.rx_valid), 32'd1);
    chk("ovr_data",  32'(bus.rx_data), 32'h12);
    chk("ovr_rts",   32'(bus.rts), 32'd0);
    chk("ovr_pulses", 32'(ovr_cnt), 32'd1);
    @(posedge clk); #1 bus.rx_ready = 1'b1;
    @(posedge clk); #1 bus.rx_ready = 1'b0;
    chk("ovr_drain_valid", 32'(bus.rx_valid), 32'd0);
    chk("ovr_drain_rts",   32'(bus.rts), 32'd1);
    check_frame("ovr_held", 8'h12, 1'b0, 1'b0);
    bus.rx_ready = 1'b1;

    // reset in the middle of data bit 3 of 0xFF
    bus.rx_in = 1'b0;
    wait_ticks(16);
    bus.rx_in = 1'b1;
    wait_ticks(56);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mrst_valid", 32'(bus.rx_valid), 32'd0);
    chk("mrst_data",  32'(bus.rx_data), 32'd0);
    chk("mrst_perr",  32'(bus.parity_err), 32'd0);
    chk("mrst_ferr",  32'(bus.frame_err), 32'd0);
    chk("mrst_busy",  32'(bus.rx_busy), 32'd0);
    chk("mrst_rts",   32'(bus.rts), 32'd1);
    rst = 1'b0;
    wait_ticks(120);
    chk("mrst_no_frame", 32'(got_q.size()), 32'd0);
    send_frame(8'h00, 1'b0, 1'b1);
    wait_ticks(8);
    check_frame("mrst_next", 8'h00, 1'b0, 1'b0);

    // randomized frames: first three back-to-back and clean
    exp_q.delete();
    got_q.delete();
    for (int i = 0; i < 12; i++) begin
      d  = 8'($urandom_range(0, 255));
      pb = 1'(($countones(d) + PT) % 2);
      sb = 1'b1;
      if (i >= 3) begin
        if ($urandom_range(0, 3) == 0) pb = ~pb;
        if ($urandom_range(0, 3) == 0) sb = 1'b0;
      end
      pe = 1'(((($countones(d) + int'(pb)) % 2) != PT));
      fe = ~sb;
      exp_q.push_back({d, pe, fe});
      send_frame(d, pb, sb);
      if (!sb) begin
        bus.rx_in = 1'b1;
        wait_ticks(16);
      end
    end
    wait_ticks(32);
    chk("rand_count", 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      chk("rand_frame", 32'(g), 32'(e));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, number of data bits per frame (5..9).
REQ-002 SHALL have parameter PARITY_EN, default 1, 1 = a parity bit follows the data bits.
REQ-003 SHALL have parameter PARITY_TYPE, default 0, 0 = even parity, 1 = odd parity.
REQ-004 SHALL have parameter STOP_BITS, default 1, number of stop bits (1 or 2).
REQ-005 SHALL have port clk  input  1  system clock; all logic is on the rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port tick_16x  input  1  one-clk strobe at 16x the baud rate, from baudrate_gen.
REQ-008 SHALL have port rx_in  input  1  asynchronous serial line; idles high.
REQ-009 SHALL have port rx_ready  input  1  consumer accepts rx_data when high while rx_valid is high.
REQ-010 SHALL have port rx_data  output  DATA_BITS  received data word, LSB first on the line.
REQ-011 SHALL have port rx_valid  output  1  rx_data and the error flags are valid.
REQ-012 SHALL have port parity_err  output  1  parity mismatch on the held frame.
REQ-013 SHALL have port frame_err  output  1  a stop bit of the held frame sampled 0.
REQ-014 SHALL have port overrun  output  1  one-clk pulse when a completed frame is dropped.
REQ-015 SHALL have port rts  output  1  flow control to the far end; equals !rx_valid.
REQ-016 SHALL have port rx_busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-017 SHALL pass rx_in through a 2-flop synchronizer; all sampling uses the synchronized value (rxs).
REQ-018 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP and WAIT_HIGH.
REQ-019 SHALL keep a 4-bit tick counter that advances only on tick_16x and clears on every state entry.
REQ-020 SHALL, in IDLE, move to START when rxs = 0.
REQ-021 SHALL, in START, sample rxs on the 8th tick_16x: 0 -> DATA; 1 -> IDLE as a false start, with no outputs changed.
REQ-022 SHALL, in DATA, sample rxs on every 16th tick and shift it in LSB first; after DATA_BITS samples go to PARITY if PARITY_EN = 1, else to STOP.
REQ-023 SHALL, in PARITY, sample on the 16th tick and flag an error when (^data ^ PARITY_TYPE) != sample.
REQ-024 SHALL, in STOP, sample each of the STOP_BITS stop bits on its 16th tick; any 0 sample sets the frame error.
REQ-025 SHALL complete the frame on the last stop sample: if rx_valid = 0, or rx_ready = 1 in the same clk, load rx_data, parity_err and frame_err and set rx_valid = 1 on the next clk.
REQ-026 SHALL, when a frame completes while rx_valid = 1 and rx_ready = 0, keep the held word and flags unchanged, drop the new frame, and pulse overrun for one clk.
REQ-027 SHALL clear rx_valid the clk after rx_valid & rx_ready, unless a new frame loads in that same clk (REQ-025).
REQ-028 SHALL, after the last stop sample, go to IDLE if rxs = 1, else to WAIT_HIGH, which exits to IDLE only when rxs = 1 (break handling).
REQ-029 SHALL keep the flags of the held frame valid until it is consumed; parity_err and frame_err are meaningful only while rx_valid = 1.
REQ-030 SHALL hold state, counter and shift register unchanged in clks where tick_16x = 0.

Reset
REQ-031 SHALL, when rst = 1 at a clk edge, enter IDLE and set rx_data = 0, rx_valid = 0, parity_err = 0, frame_err = 0, overrun = 0, rx_busy = 0, and rts = 1.
REQ-032 SHALL set both synchronizer flops to 1 on reset.
REQ-033 SHALL abandon any frame in progress on reset mid-frame and not deliver it.

Verification
REQ-034 Frame 0x55 with even parity bit 0 and stop 1, rx_ready held high -> rx_valid pulses, rx_data = 0x55, parity_err = 0, frame_err = 0.
REQ-035 Low glitch on rx_in of 4 tick_16x periods -> FSM returns to IDLE, rx_valid stays 0, rx_busy is high for at most 8 ticks.
REQ-036 Frame 0x33 sent with parity bit 1 -> rx_data = 0x33, parity_err = 1; frame 0xA5 with stop bit 0 -> frame_err = 1 and FSM in WAIT_HIGH until the line returns high.
REQ-037 Frames 0x12 then 0x34 with rx_ready = 0 -> rx_data = 0x12 held, one overrun pulse, rts = 0; rx_ready pulse then clears rx_valid and sets rts = 1.
REQ-038 rst asserted during data bit 3 of frame 0xFF -> all outputs at reset values; next frame 0x00 is received correctly.
REQ-039 Loopback from uart_tx: 3 random bytes sent back-to-back -> every byte matches, with no errors.
